// File: rtl/game_ctrl.sv
// Game-flow controller: sequences idle/play/hit/over and owns lives, score,
// high score, post-hit invincibility and star consumption. All outputs registered.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int HIT_TICKS    = 30,
  parameter int INVINC_TICKS = 64,
  parameter int STAR_BONUS   = 5,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               collision_tube,
  input  logic               collision_star,
  input  logic               tube_passed,
  output logic [1:0]         state,
  output logic               scroll_en,
  output logic               ta_visible,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               game_over,
  output logic               star_clear
);

  localparam int HW = $clog2(HIT_TICKS + 1);
  // At least 3 bits so the blink tap (bit 2) always exists.
  localparam int IW = ($clog2(INVINC_TICKS + 1) < 3) ? 3 : $clog2(INVINC_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [HW-1:0]      hit_cnt_q, hit_cnt_d;
  logic [IW-1:0]      invinc_q, invinc_d;
  logic               star_prev_q, star_prev_d;
  logic               star_clear_q, star_clear_d;
  logic               scroll_en_q, scroll_en_d;
  logic               ta_visible_q, ta_visible_d;
  logic               game_over_q, game_over_d;

  logic               star_edge;
  logic               tube_hit;
  logic [SCORE_W:0]   add_v;
  logic [SCORE_W:0]   sum_v;

  assign star_edge = collision_star & ~star_prev_q;

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    score_d      = score_q;
    high_d       = high_q;
    hit_cnt_d    = hit_cnt_q;
    invinc_d     = invinc_q;
    star_prev_d  = collision_star;
    star_clear_d = 1'b0;
    tube_hit     = 1'b0;
    add_v        = '0;
    sum_v        = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PLAY;
          score_d  = '0;
          lives_d  = 2'(LIVES);
          invinc_d = '0;
        end
      end
      S_PLAY: begin
        tube_hit = collision_tube && (invinc_q == '0);
        if (frame_tick && (invinc_q != '0)) invinc_d = invinc_q - IW'(1);
        if (tube_passed && !tube_hit) add_v = add_v + (SCORE_W+1)'(1);
        if (star_edge) begin
          add_v        = add_v + (SCORE_W+1)'(STAR_BONUS);
          star_clear_d = 1'b1;
        end
        // One extra bit catches overflow so the score clamps instead of wrapping.
        sum_v   = {1'b0, score_q} + add_v;
        score_d = sum_v[SCORE_W] ? '1 : sum_v[SCORE_W-1:0];
        if (tube_hit) begin
          if (lives_q == 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d   = lives_q - 2'd1;
            state_d   = S_HIT;
            hit_cnt_d = HW'(HIT_TICKS);
          end
        end
      end
      S_HIT: begin
        if (frame_tick) begin
          hit_cnt_d = hit_cnt_q - HW'(1);
          if (hit_cnt_q == HW'(1)) begin
            state_d  = S_PLAY;
            invinc_d = IW'(INVINC_TICKS);
          end
        end
      end
      S_OVER: begin
        if (score_q > high_q) high_d = score_q;
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    scroll_en_d  = (state_d == S_PLAY);
    game_over_d  = (state_d == S_OVER);
    ta_visible_d = (state_d != S_PLAY) || (invinc_d == '0) || !invinc_d[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lives_q      <= 2'(LIVES);
      score_q      <= '0;
      high_q       <= '0;
      hit_cnt_q    <= '0;
      invinc_q     <= '0;
      star_prev_q  <= 1'b0;
      star_clear_q <= 1'b0;
      scroll_en_q  <= 1'b0;
      ta_visible_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      high_q       <= high_d;
      hit_cnt_q    <= hit_cnt_d;
      invinc_q     <= invinc_d;
      star_prev_q  <= star_prev_d;
      star_clear_q <= star_clear_d;
      scroll_en_q  <= scroll_en_d;
      ta_visible_q <= ta_visible_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign scroll_en  = scroll_en_q;
  assign ta_visible = ta_visible_q;
  assign game_over  = game_over_q;
  assign star_clear = star_clear_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: full game flow on default parameters plus a
// narrow-score instance for saturation.
module tb_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0;
  logic       collision_tube = 1'b0, collision_star = 1'b0, tube_passed = 1'b0;
  logic [1:0] state, lives;
  logic       scroll_en, ta_visible, game_over, star_clear;
  logic [9:0] score, high_score;

  logic       s_start = 1'b0, s_star = 1'b0, s_pass = 1'b0;
  logic [1:0] s_state, s_lives;
  logic       s_scroll, s_ta, s_go, s_clear;
  logic [3:0] s_score, s_high;

  int checks = 0;
  int failures = 0;
  int clears;

  game_ctrl #(.LIVES(3), .HIT_TICKS(30), .INVINC_TICKS(64), .STAR_BONUS(5), .SCORE_W(10)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .collision_tube(collision_tube), .collision_star(collision_star),
    .tube_passed(tube_passed), .state(state), .scroll_en(scroll_en),
    .ta_visible(ta_visible), .lives(lives), .score(score),
    .high_score(high_score), .game_over(game_over), .star_clear(star_clear)
  );

  game_ctrl #(.LIVES(3), .HIT_TICKS(30), .INVINC_TICKS(64), .STAR_BONUS(5), .SCORE_W(4)) dut_small (
    .clk(clk), .rst(rst), .frame_tick(1'b0), .start(s_start),
    .collision_tube(1'b0), .collision_star(s_star),
    .tube_passed(s_pass), .state(s_state), .scroll_en(s_scroll),
    .ta_visible(s_ta), .lives(s_lives), .score(s_score),
    .high_score(s_high), .game_over(s_go), .star_clear(s_clear)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic pass_n(input int n);
    for (int i = 0; i < n; i++) begin
      tube_passed = 1'b1; step();
      tube_passed = 1'b0; step();
    end
  endtask

  initial begin
    int exp_ta;
    #1;
    // Reset
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_scroll", scroll_en, 0);
    chk("rst_ta", ta_visible, 1);
    chk("rst_high", high_score, 0);
    chk("rst_go", game_over, 0);
    chk("rst_clear", star_clear, 0);
    rst = 1'b0;
    step();
    chk("idle_hold", state, 0);

    // Saturation on the 4-bit instance: 14 + 5 clamps to 15
    s_start = 1'b1; step(); s_start = 1'b0; step();
    chk("s_play", s_state, 1);
    for (int i = 0; i < 14; i++) begin
      s_pass = 1'b1; step(); s_pass = 1'b0; step();
    end
    chk("s_score14", s_score, 14);
    s_star = 1'b1; step();
    chk("s_sat_star", s_score, 15);
    chk("s_sat_clear", s_clear, 1);
    s_star = 1'b0; s_pass = 1'b1; step(); s_pass = 1'b0; step();
    chk("s_sat_pass", s_score, 15);

    // Start
    start = 1'b1; step(); start = 1'b0;
    chk("start_state", state, 1);
    chk("start_scroll", scroll_en, 1);
    chk("start_ta", ta_visible, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("start_ignored_play", state, 1);

    // Tube passes
    pass_n(4);
    chk("score4", score, 4);

    // Held star scores once
    collision_star = 1'b1; step();
    chk("star_clear_first", star_clear, 1);
    chk("star_score", score, 9);
    clears = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (star_clear) clears++;
    end
    chk("star_clear_extra", clears, 0);
    chk("star_held_score", score, 9);
    collision_star = 1'b0; step();

    // Non-fatal hit
    collision_tube = 1'b1; frame_tick = 1'b1; step();
    collision_tube = 1'b0; frame_tick = 1'b0;
    chk("hit_lives", lives, 2);
    chk("hit_state", state, 2);
    chk("hit_scroll", scroll_en, 0);
    start = 1'b1; tube_passed = 1'b1; step(); start = 1'b0; tube_passed = 1'b0;
    chk("hit_ignore_start", state, 2);
    chk("hit_ignore_pass", score, 9);
    tick_n(29);
    chk("hit_29", state, 2);
    tick_n(1);
    chk("hit_exit", state, 1);
    chk("hit_exit_scroll", scroll_en, 1);
    chk("hit_exit_ta", ta_visible, 1);

    // Immunity window with collision held
    for (int k = 1; k <= 64; k++) begin
      collision_tube = 1'b1; frame_tick = 1'b1; step();
      frame_tick = 1'b0;
      if (k == 64) collision_tube = 1'b0;
      case (k)
        1, 4:      exp_ta = 0;
        5, 8, 64:  exp_ta = 1;
        9:         exp_ta = 0;
        default:   exp_ta = -1;
      endcase
      if (exp_ta >= 0) chk($sformatf("blink_k%0d", k), ta_visible, exp_ta);
      step();
    end
    chk("immune_lives", lives, 2);
    chk("immune_state", state, 1);
    collision_tube = 1'b1; frame_tick = 1'b1; step();
    collision_tube = 1'b0; frame_tick = 1'b0;
    chk("tick65_lives", lives, 1);
    chk("tick65_state", state, 2);

    // Fatal hit at score 12
    tick_n(30);
    pass_n(3);
    chk("score12", score, 12);
    tick_n(64);
    collision_tube = 1'b1; step(); collision_tube = 1'b0;
    chk("over_state", state, 3);
    chk("over_go", game_over, 1);
    chk("over_lives", lives, 0);
    chk("over_scroll", scroll_en, 0);
    step();
    chk("high12", high_score, 12);
    chk("over_score_held", score, 12);

    // Second game: simultaneous events, lower final score
    start = 1'b1; step(); start = 1'b0;
    chk("over_to_idle", state, 0);
    step();
    chk("idle_needs_start", state, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("g2_score0", score, 0);
    chk("g2_lives3", lives, 3);
    pass_n(3);
    collision_tube = 1'b1; tube_passed = 1'b1; collision_star = 1'b1; step();
    collision_tube = 1'b0; tube_passed = 1'b0; collision_star = 1'b0;
    chk("simul_score", score, 8);
    chk("simul_lives", lives, 2);
    chk("simul_state", state, 2);
    chk("simul_clear", star_clear, 1);
    tick_n(30); tick_n(64);
    collision_tube = 1'b1; step(); collision_tube = 1'b0;
    chk("g2_hit2", lives, 1);
    tick_n(30); tick_n(64);
    collision_tube = 1'b1; step(); collision_tube = 1'b0;
    chk("g2_over", state, 3);
    step(); step();
    chk("g2_high_kept", high_score, 12);
    chk("g2_score_held", score, 8);

    // Reset mid-HIT
    start = 1'b1; step(); step(); start = 1'b0;
    chk("g3_play", state, 1);
    collision_tube = 1'b1; step(); collision_tube = 1'b0;
    tick_n(5);
    chk("g3_hit", state, 2);
    rst = 1'b1; step();
    chk("mid_rst_state", state, 0);
    chk("mid_rst_lives", lives, 3);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_high", high_score, 0);
    chk("mid_rst_scroll", scroll_en, 0);
    chk("mid_rst_ta", ta_visible, 1);
    chk("mid_rst_go", game_over, 0);
    rst = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
